// File: rtl/upower_pkg.sv
// Shared definitions for the uPOWER fetch-stage PC sequencer: state
// encoding, instruction size and the architectural boot address.
package upower_pkg;

  // Sequencer states: BOOT after reset, RUN for normal fetch, HOLD while a
  // redirect waits for the outstanding fetch to be accepted.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  // Every uPOWER instruction is one 32-bit word.
  localparam int unsigned INSTR_BYTES = 4;

  // Boot address used when the top does not override it.
  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0000_0000_0004_0000;

endpackage : upower_pkg

// File: rtl/pc_target_calc.sv
// Branch target computation: sign-extends the LI word offset, converts it to
// a byte offset and either uses it directly (AA=1) or adds it to the branch
// instruction address (AA=0). All arithmetic wraps at XLEN bits.
module pc_target_calc #(
  parameter int XLEN  = 64,
  parameter int IMM_W = 24
) (
  input  logic              i_br_abs,
  input  logic [IMM_W-1:0]  i_br_imm,
  input  logic [XLEN-1:0]   i_br_pc,
  output logic [XLEN-1:0]   o_target
);

  logic [XLEN-1:0] w_sext;
  logic [XLEN-1:0] w_offset;

  // Extend to full width before shifting so negative offsets stay negative.
  assign w_sext   = {{(XLEN-IMM_W){i_br_imm[IMM_W-1]}}, i_br_imm};
  assign w_offset = w_sext << 2;

  // Select absolute or PC-relative target.
  always_comb begin
    o_target = w_offset;
    if (i_br_abs) begin
      o_target = w_offset;
    end else begin
      o_target = i_br_pc + w_offset;
    end
  end

endmodule : pc_target_calc

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the uPOWER fetch stage. Issues word-aligned
// fetch addresses over a valid/ready handshake, applies branch and redirect
// targets, and parks a redirect that arrives while a fetch is still waiting
// for acceptance so that the presented address never changes mid-handshake.
module pc_sequencer
  import upower_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              IMM_W        = 24,
  parameter int              CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic              br_abs,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [XLEN-1:0]   br_pc,
  input  logic              redir_valid,
  input  logic [XLEN-1:0]   redir_pc,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic [CNT_W-1:0]  fetch_count
);

  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_pend_nxt;
  logic            r_pend_redir;      // pending target came from redir_valid
  logic            w_pend_redir_nxt;
  logic            r_outstanding;     // last cycle presented an unaccepted fetch
  logic [CNT_W-1:0] r_count;

  logic            w_fetch_valid;
  logic            w_accept;
  logic            w_blocked;
  logic            w_req;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_redir_tgt;
  logic [XLEN-1:0] w_req_tgt;
  logic [XLEN-1:0] w_pc_plus4;

  pc_target_calc #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W)
  ) u_target (
    .i_br_abs (br_abs),
    .i_br_imm (br_imm),
    .i_br_pc  (br_pc),
    .o_target (w_br_tgt)
  );

  // Redirect targets are forced to a word boundary.
  assign w_redir_tgt = redir_pc & ~XLEN'(3);
  assign w_req       = redir_valid | br_taken;
  assign w_req_tgt   = redir_valid ? w_redir_tgt : w_br_tgt;
  assign w_pc_plus4  = r_pc + XLEN'(INSTR_BYTES);
  assign w_accept    = w_fetch_valid & fetch_ready;
  assign w_blocked   = w_fetch_valid & ~fetch_ready;

  // Fetch request: a request left unaccepted stays up even if stall rises.
  always_comb begin
    w_fetch_valid = 1'b0;
    case (r_state)
      ST_BOOT: w_fetch_valid = 1'b0;
      ST_RUN:  w_fetch_valid = ~stall | r_outstanding;
      ST_HOLD: w_fetch_valid = 1'b1;
      default: w_fetch_valid = 1'b0;
    endcase
  end

  // Next-state, next-PC and pending-target selection.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_nxt       = r_pend_pc;
    w_pend_redir_nxt = r_pend_redir;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
        if (redir_valid) begin
          w_pc_nxt = w_redir_tgt;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      ST_RUN: begin
        if (w_req && w_blocked) begin
          // Address is on the bus unaccepted: park the target.
          w_pend_nxt       = w_req_tgt;
          w_pend_redir_nxt = redir_valid;
          w_state_nxt      = ST_HOLD;
        end else if (w_req) begin
          w_pc_nxt = w_req_tgt;
        end else if (w_accept) begin
          w_pc_nxt = w_pc_plus4;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      ST_HOLD: begin
        // A redirect always replaces the parked target; a branch only
        // replaces a parked branch.
        if (redir_valid) begin
          w_pend_nxt       = w_redir_tgt;
          w_pend_redir_nxt = 1'b1;
        end else if (br_taken && !r_pend_redir) begin
          w_pend_nxt       = w_br_tgt;
          w_pend_redir_nxt = 1'b0;
        end else begin
          w_pend_nxt       = r_pend_pc;
          w_pend_redir_nxt = r_pend_redir;
        end
        if (w_accept) begin
          w_pc_nxt         = w_pend_nxt;
          w_pend_redir_nxt = 1'b0;
          w_state_nxt      = ST_RUN;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      default: begin
        w_state_nxt      = ST_BOOT;
        w_pc_nxt         = RESET_VECTOR;
        w_pend_redir_nxt = 1'b0;
      end
    endcase
  end

  // State, PC and pending-target registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_pend_pc     <= RESET_VECTOR;
      r_pend_redir  <= 1'b0;
      r_outstanding <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend_pc     <= w_pend_nxt;
      r_pend_redir  <= w_pend_redir_nxt;
      r_outstanding <= w_blocked;
    end
  end

  // Accepted-fetch counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign fetch_valid = w_fetch_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fetch_count = r_count;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. The fetch counter is instantiated narrow
// so that its wrap-around is reachable in a short run.
module tb_pc_sequencer;

  localparam int XLEN  = 64;
  localparam int IMM_W = 24;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              br_taken;
  logic              br_abs;
  logic [IMM_W-1:0]  br_imm;
  logic [XLEN-1:0]   br_pc;
  logic              redir_valid;
  logic [XLEN-1:0]   redir_pc;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus4;
  logic [CNT_W-1:0]  fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(
    .XLEN         (XLEN),
    .RESET_VECTOR (64'h0000_0000_0004_0000),
    .IMM_W        (IMM_W),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_abs      (br_abs),
    .br_imm      (br_imm),
    .br_pc       (br_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_count (fetch_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [63:0] e_pc,
                           input logic e_valid, input logic [63:0] e_cnt);
    check_eq({tag, ".pc"}, pc, e_pc);
    check_eq({tag, ".valid"}, {63'd0, fetch_valid}, {63'd0, e_valid});
    check_eq({tag, ".cnt"}, {60'd0, fetch_count}, e_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_abs = 1'b0;
    br_imm = 24'd0; br_pc = 64'd0; redir_valid = 1'b0; redir_pc = 64'd0;
    fetch_ready = 1'b1;
    tick(); tick();
    check_bus("reset", 64'h40000, 1'b0, 64'd0);
    check_eq("reset.plus4", pc_plus4, 64'h40004);

    rst = 1'b1;
    #1;
    check_bus("boot", 64'h40000, 1'b0, 64'd0);
    tick();
    check_bus("run0", 64'h40000, 1'b1, 64'd0);
    tick();
    check_bus("run1", 64'h40004, 1'b1, 64'd1);
    tick();
    check_bus("run2", 64'h40008, 1'b1, 64'd2);

    // Memory not ready: address and request must hold.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bus("notready", 64'h40008, 1'b1, 64'd2);
    end
    fetch_ready = 1'b1;
    tick();
    check_bus("ready", 64'h4000C, 1'b1, 64'd3);

    // Relative branch: 0x40010 + (-4 << 2).
    br_taken = 1'b1; br_abs = 1'b0; br_pc = 64'h40010; br_imm = 24'hFFFFFC;
    tick();
    check_bus("br_rel", 64'h40000, 1'b1, 64'd4);
    br_abs = 1'b1; br_imm = 24'h000100;
    tick();
    check_bus("br_abs", 64'h400, 1'b1, 64'd5);
    br_taken = 1'b0; br_abs = 1'b0;

    redir_valid = 1'b1; redir_pc = 64'h40020;
    tick();
    check_bus("redir", 64'h40020, 1'b1, 64'd6);
    redir_valid = 1'b0;

    // Redirect while blocked parks in HOLD.
    fetch_ready = 1'b0;
    tick();
    check_bus("blk", 64'h40020, 1'b1, 64'd6);
    redir_valid = 1'b1; redir_pc = 64'h7003;
    tick();
    check_bus("hold", 64'h40020, 1'b1, 64'd6);
    check_eq("hold.state", {62'd0, dut.r_state}, 64'd2);
    redir_valid = 1'b0;
    // A branch cannot displace a parked redirect.
    br_taken = 1'b1; br_abs = 1'b1; br_imm = 24'h000100;
    tick();
    check_bus("hold_br", 64'h40020, 1'b1, 64'd6);
    br_taken = 1'b0; br_abs = 1'b0;
    fetch_ready = 1'b1;
    tick();
    check_bus("hold_acc", 64'h7000, 1'b1, 64'd7);

    // Redirect and branch together: redirect wins.
    redir_valid = 1'b1; redir_pc = 64'h8000;
    br_taken = 1'b1; br_abs = 1'b1; br_imm = 24'h002400;
    tick();
    check_bus("simul", 64'h8000, 1'b1, 64'd8);
    redir_valid = 1'b0; br_taken = 1'b0; br_abs = 1'b0;

    // Stall with nothing outstanding drops the request.
    stall = 1'b1;
    tick();
    check_bus("stall", 64'h8000, 1'b0, 64'd8);
    redir_valid = 1'b1; redir_pc = 64'h5000;
    tick();
    check_bus("stall_redir", 64'h5000, 1'b0, 64'd8);
    redir_valid = 1'b0; stall = 1'b0;
    #1;
    check_bus("unstall", 64'h5000, 1'b1, 64'd8);
    tick();
    check_bus("unstall_acc", 64'h5004, 1'b1, 64'd9);

    // Stall raised mid-handshake keeps the request until accepted.
    fetch_ready = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    check_bus("stall_mid", 64'h5004, 1'b1, 64'd9);
    fetch_ready = 1'b1;
    tick();
    check_bus("stall_acc", 64'h5008, 1'b0, 64'd10);
    stall = 1'b0;

    // PC wrap.
    redir_valid = 1'b1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    check_bus("pc_top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'd11);
    check_eq("plus4_wrap", pc_plus4, 64'd0);
    redir_valid = 1'b0;
    tick();
    check_bus("pc_wrap", 64'd0, 1'b1, 64'd12);
    tick(); tick(); tick();
    check_bus("cnt_max", 64'hC, 1'b1, 64'd15);
    tick();
    check_bus("cnt_wrap", 64'h10, 1'b1, 64'd0);

    // Reset in HOLD drops the pending redirect.
    fetch_ready = 1'b0;
    tick();
    redir_valid = 1'b1; redir_pc = 64'h6000;
    tick();
    check_eq("hold2.state", {62'd0, dut.r_state}, 64'd2);
    redir_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_bus("rst_hold", 64'h40000, 1'b0, 64'd0);
    rst = 1'b1; fetch_ready = 1'b1;
    #1;
    check_bus("rst_boot", 64'h40000, 1'b0, 64'd0);
    tick();
    check_bus("rst_run", 64'h40000, 1'b1, 64'd0);
    tick();
    check_bus("rst_next", 64'h40004, 1'b1, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pc_sequencer
